// File: rtl/data_sram_responder_pkg.sv
// Shared constants and address helpers for the data SRAM responder.
package data_sram_responder_pkg;

  localparam int unsigned DataW      = 32;
  localparam int unsigned LatencyMin = 1;
  localparam int unsigned LatencyMax = 4;

  // Byte address to word index; the caller truncates to its own index width.
  function automatic logic [31:0] word_index(input logic [31:0] addr);
    return addr >> 2;
  endfunction

  // An address is in range when every bit above the word index is zero.
  function automatic logic in_range(input logic [31:0] addr, input int unsigned addr_w);
    return (addr >> (addr_w + 2)) == 32'd0;
  endfunction

endpackage

// File: rtl/data_sram_responder_byte_we_ram.sv
// Single-port word array with byte strobes and a registered read port.
module byte_we_ram
  import data_sram_responder_pkg::*;
#(
  parameter int unsigned AddrW = 14
) (
  input  logic             clk_i,
  input  logic [3:0]       we_i,
  input  logic             re_i,
  // Synchronous clear of the read register (maps onto the block RAM output reset)
  input  logic             clr_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [DataW-1:0] wdata_i,
  output logic [DataW-1:0] rdata_o
);

  logic [DataW-1:0] mem_q [2**AddrW];
  logic [DataW-1:0] rdata_q;

  // Byte-lane writes; contents are never reset.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 4; i++) begin
      if (we_i[i]) begin
        mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  // Registered read; holds its value when neither read nor clear is requested.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_sram_responder.sv
// Data SRAM responder: range decode, fixed-latency response pipeline and request counters.
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int unsigned ADDR_W  = 14,
  parameter int unsigned LATENCY = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             data_sram_en,
  input  logic [3:0]       data_sram_we,
  input  logic [31:0]      data_sram_addr,
  input  logic [DataW-1:0] data_sram_wdata,
  output logic [DataW-1:0] data_sram_rdata,
  output logic             rdata_valid,
  output logic             access_err,
  output logic [31:0]      rd_count,
  output logic [31:0]      wr_count
);

  if (LATENCY < LatencyMin || LATENCY > LatencyMax) begin : g_bad_latency
    $error("LATENCY must be in 1..4");
  end

  logic              req_ok;
  logic              is_wr;
  logic              in_rng;
  logic [3:0]        ram_we;
  logic              ram_re;
  logic              ram_clr;
  logic [ADDR_W-1:0] ram_idx;
  logic [DataW-1:0]  ram_rdata;
  logic [DataW-1:0]  data_out;
  logic              rsp_valid;
  logic              rsp_err;

  logic [LATENCY-1:0] valid_q;
  logic [LATENCY-1:0] err_q;
  logic [31:0]        rd_count_q;
  logic [31:0]        wr_count_q;

  // A request coinciding with reset is ignored entirely.
  assign req_ok    = data_sram_en && !reset;
  assign is_wr     = |data_sram_we;
  assign in_rng    = in_range(data_sram_addr, ADDR_W);
  assign ram_idx   = ADDR_W'(word_index(data_sram_addr));
  assign ram_we    = (req_ok && in_rng) ? data_sram_we : 4'b0000;
  assign ram_re    = req_ok && !is_wr && in_rng;
  // Out-of-range reads answer zero; reset also zeroes the first stage.
  assign ram_clr   = reset || (req_ok && !is_wr && !in_rng);
  assign rsp_valid = req_ok && !is_wr;
  assign rsp_err   = req_ok && !in_rng;

  byte_we_ram #(
    .AddrW(ADDR_W)
  ) u_ram (
    .clk_i  (clk),
    .we_i   (ram_we),
    .re_i   (ram_re),
    .clr_i  (ram_clr),
    .addr_i (ram_idx),
    .wdata_i(data_sram_wdata),
    .rdata_o(ram_rdata)
  );

  // Valid/error shift; stage 0 lines up with the RAM read register.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      err_q   <= '0;
    end else begin
      valid_q[0] <= rsp_valid;
      err_q[0]   <= rsp_err;
      for (int k = 1; k < LATENCY; k++) begin
        valid_q[k] <= valid_q[k-1];
        err_q[k]   <= err_q[k-1];
      end
    end
  end

  if (LATENCY == 1) begin : g_direct
    assign data_out = ram_rdata;
  end else begin : g_pipe
    logic [DataW-1:0] data_q [LATENCY-1];

    // Later data stages only load when a read occupies the previous stage, so the output holds.
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int k = 0; k < LATENCY - 1; k++) begin
          data_q[k] <= '0;
        end
      end else begin
        if (valid_q[0]) begin
          data_q[0] <= ram_rdata;
        end
        for (int k = 1; k < LATENCY - 1; k++) begin
          if (valid_q[k]) begin
            data_q[k] <= data_q[k-1];
          end
        end
      end
    end

    assign data_out = data_q[LATENCY-2];
  end

  // Request counters; out-of-range requests count, wrap is natural.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else if (req_ok) begin
      if (is_wr) begin
        wr_count_q <= wr_count_q + 32'd1;
      end else begin
        rd_count_q <= rd_count_q + 32'd1;
      end
    end
  end

  assign data_sram_rdata = data_out;
  assign rdata_valid     = valid_q[LATENCY-1];
  assign access_err      = err_q[LATENCY-1];
  assign rd_count        = rd_count_q;
  assign wr_count        = wr_count_q;

endmodule
